// File: rtl/dac_pkg.sv
// Shared definitions for the DAC sample expander.
// Default widths, ratio encodings, FSM states and the ratio clamp helper.
package dac_pkg;

    localparam int SAMPLE_W_DEF       = 8;
    localparam int N_LANES_DEF        = 32;
    localparam int MAX_RATIO_LOG2_DEF = 2;
    localparam int CNT_W_DEF          = 16;

    typedef enum logic [1:0] {
        RATIO_1 = 2'd0,
        RATIO_2 = 2'd1,
        RATIO_4 = 2'd2
    } ratio_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_e;

    function automatic logic [1:0] clamp_ratio(
        input logic [1:0] r,
        input int         max_log2
    );
        if (int'(r) > max_log2)
            return 2'(max_log2);
        return r;
    endfunction

endpackage

// File: rtl/dac_lane_mapper.sv
// Combinational lane mapper: picks N_LANES/R held samples for the current
// phase and expands each R times by repetition or zero-stuffing.
// Ports: hold_data (held input beat), phase (output phase), act_ratio
// (latched log2 ratio), act_zs (latched zero-stuff select), mapped (out beat).
module dac_lane_mapper
    import dac_pkg::*;
#(
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int N_LANES        = N_LANES_DEF,
    parameter int MAX_RATIO_LOG2 = MAX_RATIO_LOG2_DEF,
    parameter int PH_W           = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1
) (
    input  logic [N_LANES*SAMPLE_W-1:0] hold_data,
    input  logic [PH_W-1:0]             phase,
    input  logic [1:0]                  act_ratio,
    input  logic                        act_zs,
    output logic [N_LANES*SAMPLE_W-1:0] mapped
);

    always_comb begin
        mapped = '0;
        for (int j = 0; j < N_LANES; j++) begin
            int  src;
            int  rmask;
            logic keep;
            rmask = (1 << act_ratio) - 1;
            src   = int'(phase) * (N_LANES >> act_ratio) + (j >> act_ratio);
            // zero-stuff keeps only the first lane of each R-lane group
            keep  = !act_zs || ((j & rmask) == 0);
            if (keep && src < N_LANES)
                mapped[j*SAMPLE_W +: SAMPLE_W] =
                    hold_data[src*SAMPLE_W +: SAMPLE_W];
        end
    end

endmodule

// File: rtl/dac_sample_expander.sv
// Expands each N_LANES-sample AXIS beat into 2^ratio output beats.
// Ports: rf_clk/rf_rst, cfg_* (enable, ratio, zero-stuff), underrun_clr,
// s_axis_* (input beats), m_axis_* (expanded beats), underrun_cnt/flag.
module dac_sample_expander
    import dac_pkg::*;
#(
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int N_LANES        = N_LANES_DEF,
    parameter int MAX_RATIO_LOG2 = MAX_RATIO_LOG2_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic                        rf_clk,
    input  logic                        rf_rst,
    input  logic                        cfg_enable,
    input  logic [1:0]                  cfg_ratio_log2,
    input  logic                        cfg_zero_stuff,
    input  logic                        underrun_clr,
    input  logic [N_LANES*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    output logic                        s_axis_tready,
    output logic [N_LANES*SAMPLE_W-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [CNT_W-1:0]            underrun_cnt,
    output logic                        underrun_flag
);

    localparam int PH_W = (MAX_RATIO_LOG2 > 0) ? MAX_RATIO_LOG2 : 1;

    state_e                      state_q, state_d;
    logic [N_LANES*SAMPLE_W-1:0] hold_data;
    logic                        hold_last;
    logic [PH_W-1:0]             phase_q, phase_d;
    logic [1:0]                  act_ratio;
    logic                        act_zs;
    logic                        load;
    logic                        last_phase;
    logic                        m_hs;
    logic                        starve;

    assign last_phase = (phase_q == PH_W'((1 << act_ratio) - 1));
    assign m_hs       = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        load          = 1'b0;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                s_axis_tready = cfg_enable && !rf_rst;
                if (s_axis_tvalid && s_axis_tready) begin
                    load    = 1'b1;
                    phase_d = '0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                m_axis_tvalid = 1'b1;
                // refill in the closing handshake so R=1 streams gapless
                s_axis_tready = cfg_enable && m_axis_tready && last_phase;
                if (m_hs) begin
                    if (last_phase) begin
                        phase_d = '0;
                        if (s_axis_tvalid && s_axis_tready)
                            load = 1'b1;
                        else
                            state_d = S_IDLE;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            hold_data <= '0;
            hold_last <= 1'b0;
            act_ratio <= 2'(RATIO_1);
            act_zs    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (load) begin
                hold_data <= s_axis_tdata;
                hold_last <= s_axis_tlast;
                act_ratio <= clamp_ratio(cfg_ratio_log2, MAX_RATIO_LOG2);
                act_zs    <= cfg_zero_stuff;
            end
        end
    end

    assign m_axis_tlast = m_axis_tvalid && hold_last && last_phase;

    dac_lane_mapper #(
        .SAMPLE_W       (SAMPLE_W),
        .N_LANES        (N_LANES),
        .MAX_RATIO_LOG2 (MAX_RATIO_LOG2),
        .PH_W           (PH_W)
    ) u_map (
        .hold_data (hold_data),
        .phase     (phase_q),
        .act_ratio (act_ratio),
        .act_zs    (act_zs),
        .mapped    (m_axis_tdata)
    );

    assign starve = cfg_enable && m_axis_tready && !m_axis_tvalid;

    always_ff @(posedge rf_clk or posedge rf_rst) begin
        if (rf_rst) begin
            underrun_cnt  <= '0;
            underrun_flag <= 1'b0;
        end else if (underrun_clr) begin
            underrun_cnt  <= '0;
            underrun_flag <= 1'b0;
        end else if (starve) begin
            underrun_flag <= 1'b1;
            if (underrun_cnt != {CNT_W{1'b1}})
                underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_sample_expander.sv
// Scoreboard bench for dac_sample_expander.
// Expected beats are queued at each input handshake and popped per output.
module tb_dac_sample_expander;

    localparam int W    = 256;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [1:0]    cfg_ratio;
    logic          cfg_zs;
    logic          clr;
    logic [W-1:0]  s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [W-1:0]  m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [CW-1:0] ucnt;
    logic          uflag;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t sb[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    always #5 clk = ~clk;

    dac_sample_expander #(.CNT_W(CW)) dut (
        .rf_clk         (clk),
        .rf_rst         (rst),
        .cfg_enable     (cfg_enable),
        .cfg_ratio_log2 (cfg_ratio),
        .cfg_zero_stuff (cfg_zs),
        .underrun_clr   (clr),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .underrun_cnt   (ucnt),
        .underrun_flag  (uflag)
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] expand(input logic [W-1:0] d,
                                            input int rl, input int p,
                                            input logic zs);
        int r = 1 << rl;
        int k = 32 / r;
        logic [W-1:0] o = '0;
        for (int j = 0; j < 32; j++)
            if (!zs || (j % r) == 0)
                o[j*8 +: 8] = d[(p*k + j/r)*8 +: 8];
        return o;
    endfunction

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // scoreboard: push on input handshake, pop on output handshake
    always @(negedge clk) begin
        if (!rst && s_tvalid && s_tready) begin
            int rl;
            rl = (cfg_ratio > 2) ? 2 : int'(cfg_ratio);
            for (int p = 0; p < (1 << rl); p++) begin
                beat_t b;
                b.data = expand(s_tdata, rl, p, cfg_zs);
                b.last = s_tlast && (p == (1 << rl) - 1);
                sb.push_back(b);
            end
        end
        if (m_tvalid && m_tready) begin
            chk("sb_avail", W'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                beat_t e;
                e = sb.pop_front();
                chk("m_tdata", m_tdata, e.data);
                chk("m_tlast", W'(m_tlast), W'(e.last));
            end
        end
    end

    // called at posedge+1; returns at posedge+1 after the handshake
    task automatic send(input logic [W-1:0] d, input logic l);
        bit ok = 0;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_tready) begin ok = 1; break; end
        end
        if (!ok) chk("s_accept", W'(s_tready), 1);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !m_tvalid) break;
        end
        chk("drain", W'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] e0, e1, d1, seq;
        int gaps;

        rst = 1; cfg_enable = 0; cfg_ratio = 0; cfg_zs = 0; clr = 0;
        s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
        #12;
        chk("rst_s_tready", W'(s_tready), 0);
        chk("rst_m_tvalid", W'(m_tvalid), 0);
        chk("rst_m_tlast", W'(m_tlast), 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_ucnt", W'(ucnt), 0);
        chk("rst_uflag", W'(uflag), 0);
        cfg_enable = 1;
        #1 chk("rst_tready_en", W'(s_tready), 0);
        @(posedge clk); #1;
        rst = 0; m_tready = 1;
        @(posedge clk); #1;
        chk("post_rst_ucnt", W'(ucnt), 1);
        chk("post_rst_uflag", W'(uflag), 1);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;

        // R=2 hold, ramp 0x00..0x1F
        cfg_ratio = 1; cfg_zs = 0;
        for (int i = 0; i < 32; i++) seq[i*8 +: 8] = 8'(i);
        for (int j = 0; j < 32; j++) begin
            e0[j*8 +: 8] = 8'(j / 2);
            e1[j*8 +: 8] = 8'(16 + j / 2);
        end
        send(seq, 0);
        @(negedge clk);
        chk("r2_lat_valid", W'(m_tvalid), 1);
        chk("r2_beat0", m_tdata, e0);
        @(negedge clk);
        chk("r2_beat1", m_tdata, e1);
        drain();

        // R=4 zero-stuff, ramp 0x01..0x20
        cfg_ratio = 2; cfg_zs = 1;
        for (int i = 0; i < 32; i++) seq[i*8 +: 8] = 8'(i + 1);
        for (int j = 0; j < 32; j++)
            e0[j*8 +: 8] = (j % 4 == 0) ? 8'(1 + j / 4) : 8'h00;
        send(seq, 0);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            if (p == 0) chk("r4zs_beat0", m_tdata, e0);
            chk("r4zs_s_tready", W'(s_tready), W'(p == 3));
        end
        drain();

        // 8 back-to-back beats at R=2, tlast on the 8th
        cfg_ratio = 1; cfg_zs = 0;
        fork
            begin
                for (int b = 0; b < 8; b++) send(rnd_beat(), b == 7);
            end
            begin
                for (int i = 0; i < 50 && !m_tvalid; i++) @(negedge clk);
                gaps = 0;
                for (int i = 0; i < 16; i++) begin
                    if (!m_tvalid) gaps++;
                    @(negedge clk);
                end
                chk("b2b_gaps", W'(gaps), 0);
                chk("b2b_end", W'(m_tvalid), 0);
            end
        join
        drain();

        // backpressure 1,0,0,1 mid-beat
        cfg_ratio = 2; cfg_zs = 0;
        send(rnd_beat(), 1);
        @(negedge clk);
        @(posedge clk); #1 m_tready = 0;
        @(negedge clk); d1 = m_tdata;
        @(posedge clk); #1;
        @(negedge clk); chk("stall1", m_tdata, d1);
        @(posedge clk); #1 m_tready = 1;
        @(negedge clk); chk("stall2", m_tdata, d1);
        drain();

        // ratio change at a beat boundary, plus clamp of ratio 3
        cfg_ratio = 1; cfg_zs = 0;
        send(rnd_beat(), 0);
        cfg_ratio = 2;
        send(rnd_beat(), 1);
        cfg_ratio = 3; cfg_zs = 1;
        send(rnd_beat(), 1);
        drain();

        // async reset mid-beat drops the held beat
        cfg_ratio = 2; cfg_zs = 0;
        send(rnd_beat(), 1);
        @(negedge clk);
        chk("mid_valid", W'(m_tvalid), 1);
        #2 rst = 1;
        sb.delete();
        #1;
        chk("arst_valid", W'(m_tvalid), 0);
        chk("arst_last", W'(m_tlast), 0);
        @(posedge clk); #1 rst = 0;
        gaps = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (m_tvalid) gaps++;
        end
        chk("no_residual", W'(gaps), 0);
        @(posedge clk); #1;

        // underrun counting, clear priority, saturation
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        chk("clr_cnt", W'(ucnt), 0);
        chk("clr_flag", W'(uflag), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("ur5_cnt", W'(ucnt), 5);
        chk("ur5_flag", W'(uflag), 1);
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        chk("clr2_cnt", W'(ucnt), 0);
        chk("clr2_flag", W'(uflag), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("ur_sat", W'(ucnt), 15);
        cfg_enable = 0;
        clr = 1;
        @(posedge clk); #1;
        clr = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("ur_disabled", W'(ucnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_sample_expander.md
Name: dac_sample_expander

Overview:
Parametrised successor to the fixed 256b→128b→byte-duplicate DAC path. It runs in the RF clock domain after the DDR read CDC FIFO. It takes N_LANES-sample AXIS beats and emits R = 2^ratio output beats per input beat, each of the same width. Each output beat carries N_LANES/R input samples, expanded R× by either sample-hold (repetition) or zero-stuffing. It adds runtime ratio/mode select, tlast propagation and underrun accounting for the DAC stream.

Parameters:
SAMPLE_W, 8, bits per sample
N_LANES, 32, samples per beat on both input and output; must be divisible by 2^MAX_RATIO_LOG2
MAX_RATIO_LOG2, 2, largest supported log2 expansion factor (R max = 4)
CNT_W, 16, underrun counter width

Ports:
rf_clk  in  1  RF data clock, 500MHz
rf_rst  in  1  asynchronous reset, active-high
cfg_enable  in  1  accept new input beats when high
cfg_ratio_log2  in  2  log2 expansion factor; values > MAX_RATIO_LOG2 clamp to MAX_RATIO_LOG2
cfg_zero_stuff  in  1  0 = sample-hold, 1 = zero-stuff
underrun_clr  in  1  single-cycle pulse; clears underrun_cnt and underrun_flag
s_axis_tdata  in  N_LANES*SAMPLE_W  input samples; lane 0 in LSBs
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end-of-buffer marker
s_axis_tready  out  1  input ready
m_axis_tdata  out  N_LANES*SAMPLE_W  expanded samples to the RF data converter
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  last phase of a tlast input beat
m_axis_tready  in  1  RF data converter ready
underrun_cnt  out  CNT_W  saturating count of starved cycles
underrun_flag  out  1  sticky: at least one underrun since reset or clear

Behaviour:
- Reset (async, rf_rst=1) clears: hold_valid, phase, act_ratio, act_zs, tlast flag, underrun_cnt, underrun_flag. Outputs after reset: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, underrun_cnt=0, underrun_flag=0.
- Storage: one holding register (hold_data, hold_last, hold_valid) plus a phase counter, width MAX_RATIO_LOG2 (min 1 bit).
- States:
  - IDLE (hold_valid=0): s_axis_tready = cfg_enable. On handshake, load the hold register. Latch act_ratio = clamp(cfg_ratio_log2) and act_zs = cfg_zero_stuff. Set phase=0 and go to EMIT.
  - EMIT: m_axis_tvalid=1. Each m handshake advances phase.
  - On the handshake where phase = R-1: if cfg_enable && s_axis_tvalid, load the next beat in the same cycle (s_axis_tready=1, zero bubble; config re-latched) and stay in EMIT. Otherwise return to IDLE.
  - s_axis_tready is therefore combinational from m_axis_tready in EMIT.
- Latency: input handshake in cycle n → first output beat valid in cycle n+1. With m_axis_tready held high, throughput is exactly 1 input beat per R cycles, gapless.
- Lane map, with output phase p, K = N_LANES/R, output lane j, and src = p*K + floor(j/R):
  - hold mode: out[j] = in[src]
  - zero-stuff mode: out[j] = (j mod R == 0) ? in[src] : 0
  - R=1: out = in, one beat per input regardless of mode
- Phase order: p=0 first, so low lanes are emitted first.
- m_axis_tlast = hold_last && phase == R-1.
- Config changes (ratio/mode) take effect only at beat boundaries. An in-flight beat always completes with its latched config.
- cfg_enable falling mid-beat: remaining phases still emit; no new beat is accepted; then IDLE.
- m_axis_tdata holds its value while tvalid && !tready (AXIS stability rule). Data is don't-care when tvalid=0 but drives the last value; no X.
- Underrun: a cycle counts when cfg_enable=1 && m_axis_tready=1 && m_axis_tvalid=0.
  - The first counted cycle sets underrun_flag.
  - underrun_cnt saturates at 2^CNT_W-1.
  - underrun_clr has priority over an increment in the same cycle; the result is 0, flag 0.
  - The cycle after reset release with enable=1 and no data counts.
- Reset asserted mid-beat discards the held beat; no partial output follows release.

Decomposition:
- Shared package dac_pkg: SAMPLE_W/N_LANES defaults, ratio encodings (RATIO_1=0, RATIO_2=1, RATIO_4=2), clamp function for ratio_log2.
- One sub-module, dac_lane_mapper: purely combinational; inputs hold_data, phase, act_ratio, act_zs; output mapped beat.
- The top level holds the state machine, hold register and underrun counter.

Test Plan:
- R=2, hold, N_LANES=32, input bytes 0x00..0x1F, tready=1 → beat0 lanes = 00,00,01,01..0F,0F; beat1 = 10,10..1F,1F; cycles n+1, n+2.
- R=4, zero-stuff, input bytes 0x01..0x20 → beat0 lanes = 01,0,0,0,02,0,0,0..08,0,0,0; 4 beats; s_axis_tready high only in the 4th.
- 8 back-to-back beats, R=2, tready=1 → 16 consecutive valid cycles, no bubbles; tlast on beat 8 → m_axis_tlast only on output 16.
- tready toggles 1,0,0,1 during EMIT → m_axis_tdata stable while stalled; no phase skipped.
- ratio changed 1→2 mid-beat → current beat finishes with 2 phases; next beat emits 4.
- enable=1, no input for 5 cycles → underrun_cnt=5, flag=1; clr in the same cycle as a starved cycle → cnt=0, flag=0. Reset pulse mid-EMIT → tvalid=0 immediately (async); no residual beat after release.
